mul_seq_ctrl: RTL and testbench

//  Sequencer for the iterative multiplier behind ALU op MUL (ALU_ctrl 4'b0011) in the EX stage.

---
 rtl/mul_seq_ctrl_pkg.sv | 23 ++
 rtl/mul_seq_ctrl_shift_add_dp.sv | 53 +++++
 rtl/mul_seq_ctrl.sv | 100 ++++++++++
 tb/tb_mul_seq_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply sequencer: ALU control codes,
// sequencer state encoding and a counter-width helper.
package mul_seq_ctrl_pkg;

    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB = 4'b0001;
    localparam logic [3:0] ALU_OP_SLL = 4'b0010;
    localparam logic [3:0] ALU_OP_MUL = 4'b0011;
    localparam logic [3:0] ALU_OP_AND = 4'b0100;
    localparam logic [3:0] ALU_OP_OR  = 4'b0101;
    localparam logic [3:0] ALU_OP_XOR = 4'b0110;
    localparam logic [3:0] ALU_OP_SRL = 4'b0111;

    localparam logic [1:0] MS_IDLE = 2'd0;
    localparam logic [1:0] MS_BUSY = 2'd1;
    localparam logic [1:0] MS_DONE = 2'd2;

    // A single-iteration multiply still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_shift_add_dp.sv
// Shift-add multiplier datapath: accumulator, shifting multiplicand/multiplier
// and a BPC-deep partial-product adder chain, all modulo 2^WIDTH.
module mul_shift_add_dp
    import mul_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic [WIDTH-1:0] acc,
    output logic             mplier_zero
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] mplier_next;

    always_comb begin
        acc_sum = acc;
        for (int unsigned i = 0; i < BPC; i++) begin
            if (mplier[i]) begin
                acc_sum = acc_sum + (mcand << i);
            end
        end
        mplier_next = mplier >> BPC;
        // Reflects the multiplier after this step's shift, so early exit
        // can be decided on the same edge that retires the last set bits.
        mplier_zero = (mplier_next == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= src1;
            mplier <= src2;
        end else if (step) begin
            acc    <= acc_sum;
            mcand  <= mcand << BPC;
            mplier <= mplier_next;
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// EX-stage sequencer for the iterative MUL: stalls the pipeline while the
// shift-add datapath runs, then presents the low WIDTH product bits for one cycle.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned BPC        = 1,
    parameter bit          EARLY_TERM = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned N  = WIDTH / BPC;
    localparam int unsigned CW = cnt_width(N);

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] result_q;
    logic             mplier_zero;
    logic             load;
    logic             step;
    logic             last_iter;

    mul_shift_add_dp #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_dp (
        .clk         (clk_i),
        .rst         (rst_i),
        .load        (load),
        .step        (step),
        .src1        (src1_i),
        .src2        (src2_i),
        .acc         (acc),
        .mplier_zero (mplier_zero)
    );

    always_comb begin
        load      = (state == MS_IDLE) & start_i & ~flush_i & ~rst_i;
        step      = (state == MS_BUSY) & ~flush_i & ~rst_i;
        last_iter = (count == CW'(N - 1)) | (EARLY_TERM & mplier_zero);
        busy_o    = (state == MS_BUSY);
        done_o    = (state == MS_DONE) & ~flush_i & ~rst_i;
        // The held output register only refreshes on a real done pulse, so a
        // flushed DONE leaves result_o at the previous product.
        result_o  = done_o ? acc : result_q;
        stall_o   = 1'b0;
        if (!rst_i) begin
            case (state)
                MS_IDLE: stall_o = start_i & ~flush_i;
                MS_BUSY: stall_o = 1'b1;
                default: stall_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= MS_IDLE;
            count    <= '0;
            result_q <= '0;
        end else begin
            if (done_o) begin
                result_q <= acc;
            end
            if (flush_i) begin
                state <= MS_IDLE;
            end else begin
                case (state)
                    MS_IDLE: begin
                        if (start_i) begin
                            state <= MS_BUSY;
                            count <= '0;
                        end
                    end
                    MS_BUSY: begin
                        count <= count + 1'b1;
                        if (last_iter) begin
                            state <= MS_DONE;
                        end
                    end
                    // start_i seen in DONE is the retiring instruction itself.
                    MS_DONE: state <= MS_IDLE;
                    default: state <= MS_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl: full 32-cycle multiplies,
// wrap-around, flush, mid-run reset, back-to-back and early-termination builds.
module tb_mul_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        f_start, f_flush;
    logic [31:0] f_src1, f_src2, f_result;
    logic        f_stall, f_busy, f_done;
    logic        e2_start, e2_flush;
    logic [31:0] e2_src1, e2_src2, e2_result;
    logic        e2_stall, e2_busy, e2_done;
    logic        e4_start, e4_flush;
    logic [31:0] e4_src1, e4_src2, e4_result;
    logic        e4_stall, e4_busy, e4_done;

    int checks = 0;
    int errors = 0;

    mul_seq_ctrl #(.WIDTH(32), .BPC(1), .EARLY_TERM(1'b0)) u_full (
        .clk_i(clk), .rst_i(rst), .start_i(f_start), .flush_i(f_flush),
        .src1_i(f_src1), .src2_i(f_src2), .stall_o(f_stall), .busy_o(f_busy),
        .done_o(f_done), .result_o(f_result)
    );

    mul_seq_ctrl #(.WIDTH(32), .BPC(2), .EARLY_TERM(1'b1)) u_et2 (
        .clk_i(clk), .rst_i(rst), .start_i(e2_start), .flush_i(e2_flush),
        .src1_i(e2_src1), .src2_i(e2_src2), .stall_o(e2_stall), .busy_o(e2_busy),
        .done_o(e2_done), .result_o(e2_result)
    );

    mul_seq_ctrl #(.WIDTH(32), .BPC(4), .EARLY_TERM(1'b1)) u_et4 (
        .clk_i(clk), .rst_i(rst), .start_i(e4_start), .flush_i(e4_flush),
        .src1_i(e4_src1), .src2_i(e4_src2), .stall_o(e4_stall), .busy_o(e4_busy),
        .done_o(e4_done), .result_o(e4_result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full-length multiply on u_full starting in the current (IDLE) cycle;
    // returns after checking the DONE cycle T+33.
    task automatic mul_full(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        f_start = 1'b1;
        f_flush = 1'b0;
        f_src1  = a;
        f_src2  = b;
        #1;
        chk($sformatf("%s stall@T", tag), f_stall, 1);
        chk($sformatf("%s busy@T", tag), f_busy, 0);
        for (int k = 1; k <= 32; k++) begin
            next_cycle();
            f_src1 = $urandom;
            f_src2 = $urandom;
            #1;
            chk($sformatf("%s stall@T+%0d", tag, k), f_stall, 1);
            chk($sformatf("%s busy@T+%0d", tag, k), f_busy, 1);
            chk($sformatf("%s done@T+%0d", tag, k), f_done, 0);
        end
        next_cycle();
        #1;
        chk($sformatf("%s done@T+33", tag), f_done, 1);
        chk($sformatf("%s result", tag), f_result, exp);
        chk($sformatf("%s stall@T+33", tag), f_stall, 0);
        chk($sformatf("%s busy@T+33", tag), f_busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        f_start = 1'b1; f_flush = 1'b0; f_src1 = '0; f_src2 = '0;
        e2_start = 1'b0; e2_flush = 1'b0; e2_src1 = '0; e2_src2 = '0;
        e4_start = 1'b0; e4_flush = 1'b0; e4_src1 = '0; e4_src2 = '0;
        #1;
        chk("stall in reset", f_stall, 0);
        next_cycle();
        f_start = 1'b0;
        next_cycle();
        rst = 1'b0;
        #1;
        chk("reset stall", f_stall, 0);
        chk("reset busy", f_busy, 0);
        chk("reset done", f_done, 0);
        chk("reset result", f_result, 0);
        chk("reset et2 result", e2_result, 0);
        chk("reset et4 done", e4_done, 0);

        next_cycle();
        mul_full("7x6", 32'd7, 32'd6, 32'd42);
        next_cycle();
        f_start = 1'b0;
        #1;
        chk("7x6 done after", f_done, 0);
        chk("7x6 busy after", f_busy, 0);
        chk("7x6 result hold", f_result, 32'd42);

        next_cycle();
        mul_full("10000sq", 32'h0001_0000, 32'h0001_0000, 32'h0);
        next_cycle();
        mul_full("wrap", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        next_cycle();
        f_start = 1'b0;
        #1;
        chk("wrap done after", f_done, 0);

        // Flush at T+10 of a running multiply
        next_cycle();
        f_start = 1'b1; f_src1 = 32'd5; f_src2 = 32'd5;
        for (int k = 1; k <= 9; k++) begin
            next_cycle();
            #1;
            chk("flush pre busy", f_busy, 1);
        end
        next_cycle();
        f_start = 1'b0; f_flush = 1'b1;
        #1;
        chk("flush@T+10 stall", f_stall, 1);
        chk("flush@T+10 done", f_done, 0);
        next_cycle();
        f_flush = 1'b0;
        #1;
        chk("flush@T+11 busy", f_busy, 0);
        chk("flush@T+11 stall", f_stall, 0);
        chk("flush@T+11 done", f_done, 0);
        chk("flush result hold", f_result, 32'hFFFF_FFFE);
        for (int k = 0; k < 30; k++) begin
            next_cycle();
            #1;
            chk("flush no done", f_done, 0);
        end

        // Flush in IDLE with start: no start
        f_start = 1'b1; f_flush = 1'b1; f_src1 = 32'd2; f_src2 = 32'd2;
        #1;
        chk("idle flush stall", f_stall, 0);
        next_cycle();
        f_start = 1'b0; f_flush = 1'b0;
        #1;
        chk("idle flush busy", f_busy, 0);

        // Reset at T+5 of a running multiply
        next_cycle();
        f_start = 1'b1; f_src1 = 32'd5; f_src2 = 32'd7;
        for (int k = 1; k <= 4; k++) next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        chk("rst@T+5 stall", f_stall, 0);
        next_cycle();
        rst = 1'b0; f_start = 1'b0;
        #1;
        chk("rst@T+6 busy", f_busy, 0);
        chk("rst@T+6 done", f_done, 0);
        chk("rst@T+6 result", f_result, 0);
        chk("rst@T+6 stall", f_stall, 0);
        next_cycle();
        mul_full("12x11", 32'd12, 32'd11, 32'd132);

        // Back-to-back: second MUL starts in the cycle after DONE
        next_cycle();
        mul_full("3x5", 32'd3, 32'd5, 32'd15);
        next_cycle();
        mul_full("9x9", 32'd9, 32'd9, 32'd81);
        next_cycle();
        f_start = 1'b0;
        #1;
        chk("9x9 done after", f_done, 0);
        chk("9x9 result hold", f_result, 32'd81);

        // EARLY_TERM, BPC=2: 3*1 completes at T+2
        next_cycle();
        e2_start = 1'b1; e2_src1 = 32'd3; e2_src2 = 32'd1;
        #1;
        chk("et2 stall@T", e2_stall, 1);
        next_cycle();
        e2_src1 = 32'hDEAD_BEEF; e2_src2 = 32'h1234_5678;
        #1;
        chk("et2 busy@T+1", e2_busy, 1);
        chk("et2 done@T+1", e2_done, 0);
        next_cycle();
        #1;
        chk("et2 done@T+2", e2_done, 1);
        chk("et2 result", e2_result, 32'd3);
        chk("et2 stall@T+2", e2_stall, 0);
        next_cycle();
        e2_start = 1'b0;
        #1;
        chk("et2 done@T+3", e2_done, 0);

        // EARLY_TERM, BPC=4: 0x1234*0x56 exits after two nibbles (T+3)
        next_cycle();
        e4_start = 1'b1; e4_src1 = 32'h1234; e4_src2 = 32'h56;
        #1;
        chk("et4 stall@T", e4_stall, 1);
        next_cycle();
        #1;
        chk("et4 busy@T+1", e4_busy, 1);
        next_cycle();
        #1;
        chk("et4 done@T+2", e4_done, 0);
        chk("et4 stall@T+2", e4_stall, 1);
        next_cycle();
        #1;
        chk("et4 done@T+3", e4_done, 1);
        chk("et4 result", e4_result, 32'h0006_1D78);
        next_cycle();
        e4_start = 1'b0;
        #1;
        chk("et4 done@T+4", e4_done, 0);
        chk("et4 busy@T+4", e4_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
